branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_WIDTH, default 6: pattern-table index width; table depth is 2^IDX_WIDTH entries.
REQ-002 Parameter GHR_WIDTH, default 6, legal range 1..IDX_WIDTH: global history register width.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port pred_valid  input  1  fetch is presenting a PC this cycle.
REQ-006 Port pred_is_br  input  1  the fetched instruction is a conditional branch.
REQ-007 Port pred_pc  input  32  fetch PC.
REQ-008 Port pred_taken  output  1  predicted direction.
REQ-009 Port pred_idx  output  IDX_WIDTH  table index used for this prediction, carried down the pipe.
REQ-010 Port pred_ghr  output  GHR_WIDTH  GHR value used for this prediction (checkpoint), carried down the pipe.
REQ-011 Port upd_valid  input  1  a resolved conditional branch is presented this cycle.
REQ-012 Port upd_idx  input  IDX_WIDTH  pred_idx that travelled with the branch.
REQ-013 Port upd_ghr  input  GHR_WIDTH  pred_ghr that travelled with the branch.
REQ-014 Port upd_taken  input  1  resolved direction (br_en from the branch comparator).
REQ-015 Port upd_mispredict  input  1  resolved direction differs from the prediction.
REQ-016 Port stat_branches  output  32  count of accepted updates.
REQ-017 Port stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1.

Function
REQ-018 Pattern table SHALL hold 2^IDX_WIDTH 2-bit saturating counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-019 Index SHALL be pred_pc[IDX_WIDTH+1:2] XOR the current GHR, zero-extended to IDX_WIDTH.
REQ-020 pred_taken, pred_idx, pred_ghr SHALL be combinational from pred_pc and registered state (0-cycle latency); pred_taken = counter[1].
REQ-021 Outputs SHALL be driven regardless of pred_valid; with pred_valid=0 no state changes from the predict port.
REQ-022 Speculative history: on pred_valid & pred_is_br & no mispredict recovery, GHR <= {GHR[GHR_WIDTH-2:0], pred_taken} next edge.
REQ-023 Recovery: on upd_valid & upd_mispredict, GHR <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}; recovery overrides a same-cycle speculative shift.
REQ-024 Training: on upd_valid, counter[upd_idx] increments (saturating at 11) if upd_taken, else decrements (saturating at 00), next edge.
REQ-025 Same-cycle predict and update to the same index: prediction uses the pre-update counter value; no bypass.
REQ-026 stat_branches increments by 1 per upd_valid; stat_mispredicts increments by 1 per upd_valid & upd_mispredict; both saturate at 32'hFFFF_FFFF.
REQ-027 upd_mispredict SHALL be ignored when upd_valid=0.
REQ-028 GHR_WIDTH=1: shift degenerates to GHR <= new bit.

Reset
REQ-029 On rst=1 at a clock edge: all counters <= 01 (WNT), GHR <= 0, stat_branches <= 0, stat_mispredicts <= 0.
REQ-030 rst SHALL dominate every same-cycle predict or update; in-flight updates during reset are discarded.
REQ-031 After reset, pred_taken = 0 for every PC until trained.

Verification
REQ-032 Reset then pred_pc=0x0000_0040, pred_is_br=1 -> pred_idx=6'h10, pred_taken=0, pred_ghr=0.
REQ-033 Four updates upd_idx=5, upd_taken=1 -> counter 01->10->11->11 (saturated); prediction at idx 5 is taken from the first update on; stat_branches=4.
REQ-034 Three predicts with pred_is_br=1 on an untrained table -> GHR=6'b000000; then train idx to ST and predict -> GHR shifts in 1.
REQ-035 GHR=6'b000111, same-cycle pred_is_br and upd_valid/mispredict with upd_ghr=6'b101010, upd_taken=0 -> GHR=6'b010100; stat_mispredicts +1.
REQ-036 Same-cycle predict and update on idx 3 (counter 01, upd_taken=1) -> pred_taken=0 that cycle, 1 the next.
REQ-037 rst asserted mid-training with upd_valid=1 -> all counters 01, GHR 0, stats 0 next cycle; update not applied.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: gshare predictor with 2-bit saturating counters, speculative global
// history with mispredict recovery, and branch/mispredict statistics.
module branch_predictor #(
   parameter int IDX_WIDTH = 6,
   parameter int GHR_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pred_valid,
   input  logic                 pred_is_br,
   input  logic [31:0]          pred_pc,
   output logic                 pred_taken,
   output logic [IDX_WIDTH-1:0] pred_idx,
   output logic [GHR_WIDTH-1:0] pred_ghr,
   input  logic                 upd_valid,
   input  logic [IDX_WIDTH-1:0] upd_idx,
   input  logic [GHR_WIDTH-1:0] upd_ghr,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_mispredicts
);
   localparam int DEPTH = 1 << IDX_WIDTH;
   logic [1:0] pht [DEPTH];
   logic [GHR_WIDTH-1:0] ghr;
   logic [1:0] ctr, ctr_next;
   logic unused_pc;
   assign unused_pc = ^{pred_pc[31:IDX_WIDTH+2], pred_pc[1:0]};
   assign pred_idx = pred_pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr);
   assign pred_taken = pht[pred_idx][1];
   assign pred_ghr = ghr;
   always_comb begin
      ctr = pht[upd_idx];
      ctr_next = upd_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1) : (ctr == 2'b00 ? ctr : ctr - 2'd1);
   end
   // Casting {history, bit} down to GHR_WIDTH drops the oldest bit, which also covers GHR_WIDTH=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
         ghr <= '0;
         stat_branches <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid) begin
            pht[upd_idx] <= ctr_next;
            stat_branches <= stat_branches == '1 ? stat_branches : stat_branches + 32'd1;
            if (upd_mispredict)
               stat_mispredicts <= stat_mispredicts == '1 ? stat_mispredicts : stat_mispredicts + 32'd1;
         end
         if (upd_valid && upd_mispredict) ghr <= GHR_WIDTH'({upd_ghr, upd_taken});
         else if (pred_valid && pred_is_br) ghr <= GHR_WIDTH'({ghr, pred_taken});
      end
   end
endmodule
